// File: rtl/issue_unit_pkg.sv
// Shared CDB owner codes and default unit latencies for the issue scheduler.
package issue_unit_pkg;

  localparam logic [1:0] OWN_INT  = 2'd0;
  localparam logic [1:0] OWN_LDST = 2'd1;
  localparam logic [1:0] OWN_MULT = 2'd2;
  localparam logic [1:0] OWN_DIV  = 2'd3;

  localparam int INT_LAT_DEF  = 1;
  localparam int LDST_LAT_DEF = 1;
  localparam int MUL_LAT_DEF  = 4;
  localparam int DIV_LAT_DEF  = 7;

endpackage

// File: rtl/issue_unit_cdb_resv_shreg.sv
// CDB reservation window: bit k of resv_o means the CDB is taken k cycles from now.
// Each slot carries its owner code; slot 0 is what the CDB carries this cycle.
module issue_unit_cdb_resv_shreg #(
  parameter int W  = 7,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          set_i,
  input  logic [IW-1:0] set_idx_i,
  input  logic [1:0]    set_own_i,
  output logic [W-1:0]  resv_o,
  output logic [1:0]    own0_o
);

  logic [W-1:0]      resv_q, resv_d;
  logic [W-1:0][1:0] own_q, own_d;

  // Set is applied after the shift, so index L-1 lands on slot t+L.
  always_comb begin
    resv_d = resv_q >> 1;
    own_d  = '0;
    for (int k = 0; k < W - 1; k++) begin
      own_d[k] = own_q[k+1];
    end
    if (set_i) begin
      resv_d[set_idx_i] = 1'b1;
      own_d[set_idx_i]  = set_own_i;
    end
    if (flush_i) begin
      resv_d = '0;
      own_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_q <= '0;
      own_q  <= '0;
    end else begin
      resv_q <= resv_d;
      own_q  <= own_d;
    end
  end

  assign resv_o = resv_q;
  assign own0_o = own_q[0];

endmodule

// File: rtl/issue_unit.sv
// Issue scheduler: grants at most one of int/ldst/mult/div per cycle while
// keeping fixed-latency results from colliding on the CDB.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int INT_LAT  = INT_LAT_DEF,
  parameter int LDST_LAT = LDST_LAT_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       int_ready_i,
  input  logic       ldst_ready_i,
  input  logic       mult_ready_i,
  input  logic       div_ready_i,
  output logic       int_issue_o,
  output logic       ldst_issue_o,
  output logic       mult_issue_o,
  output logic       div_issue_o,
  output logic       div_busy_o,
  output logic       cdb_valid_o,
  output logic [1:0] cdb_owner_o
);

  localparam int W  = DIV_LAT;
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  logic [W-1:0]  resv;
  logic [1:0]    own0;
  logic          set_v;
  logic [IW-1:0] set_idx;
  logic [1:0]    set_own;

  logic          lru_q, lru_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          div_busy;
  logic          int_el, ldst_el, mult_el, div_el;
  logic          g_int, g_ldst, g_mult, g_div;

  // Latencies at or beyond the window edge map to a slot that is always free.
  function automatic logic slot_taken(input logic [W-1:0] r, input int l);
    slot_taken = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k == l) slot_taken = r[k];
    end
  endfunction

  issue_unit_cdb_resv_shreg #(.W(W), .IW(IW)) u_resv (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .set_i     (set_v),
    .set_idx_i (set_idx),
    .set_own_i (set_own),
    .resv_o    (resv),
    .own0_o    (own0)
  );

  assign div_busy = (div_cnt_q != '0);
  assign int_el   = int_ready_i  & ~slot_taken(resv, INT_LAT);
  assign ldst_el  = ldst_ready_i & ~slot_taken(resv, LDST_LAT);
  assign mult_el  = mult_ready_i & ~slot_taken(resv, MUL_LAT);
  assign div_el   = div_ready_i  & ~div_busy;

  always_comb begin
    g_int     = 1'b0;
    g_ldst    = 1'b0;
    g_mult    = 1'b0;
    g_div     = 1'b0;
    set_v     = 1'b0;
    set_idx   = '0;
    set_own   = OWN_INT;
    lru_d     = lru_q;
    div_cnt_d = div_busy ? div_cnt_q - 1'b1 : '0;
    if (rst_n && !flush_i) begin
      if (div_el) begin
        g_div     = 1'b1;
        set_v     = 1'b1;
        set_idx   = IW'(DIV_LAT - 1);
        set_own   = OWN_DIV;
        div_cnt_d = CW'(DIV_LAT - 1);
      end else if (mult_el) begin
        g_mult  = 1'b1;
        set_v   = 1'b1;
        set_idx = IW'(MUL_LAT - 1);
        set_own = OWN_MULT;
      end else if (int_el && (!ldst_el || lru_q)) begin
        g_int   = 1'b1;
        set_v   = 1'b1;
        set_idx = IW'(INT_LAT - 1);
        set_own = OWN_INT;
        lru_d   = 1'b0;
      end else if (ldst_el) begin
        g_ldst  = 1'b1;
        set_v   = 1'b1;
        set_idx = IW'(LDST_LAT - 1);
        set_own = OWN_LDST;
        lru_d   = 1'b1;
      end
    end
    if (flush_i) div_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q     <= 1'b1;
      div_cnt_q <= '0;
    end else begin
      lru_q     <= lru_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign int_issue_o  = g_int;
  assign ldst_issue_o = g_ldst;
  assign mult_issue_o = g_mult;
  assign div_issue_o  = g_div;
  assign div_busy_o   = div_busy;
  assign cdb_valid_o  = resv[0];
  assign cdb_owner_o  = own0;

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: arbitration, CDB slot tracking, divider pacing,
// flush and asynchronous reset behaviour.
module tb_issue_unit;
  import issue_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_i = 1'b0;
  logic       int_ready_i = 1'b0, ldst_ready_i = 1'b0, mult_ready_i = 1'b0, div_ready_i = 1'b0;
  logic       int_issue_o, ldst_issue_o, mult_issue_o, div_issue_o;
  logic       div_busy_o, cdb_valid_o;
  logic [1:0] cdb_owner_o;
  logic [3:0] iss;

  int n_tests = 0;
  int n_fail  = 0;

  issue_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .int_ready_i  (int_ready_i),
    .ldst_ready_i (ldst_ready_i),
    .mult_ready_i (mult_ready_i),
    .div_ready_i  (div_ready_i),
    .int_issue_o  (int_issue_o),
    .ldst_issue_o (ldst_issue_o),
    .mult_issue_o (mult_issue_o),
    .div_issue_o  (div_issue_o),
    .div_busy_o   (div_busy_o),
    .cdb_valid_o  (cdb_valid_o),
    .cdb_owner_o  (cdb_owner_o)
  );

  always #5 clk = ~clk;

  // {div, mult, ldst, int}
  assign iss = {div_issue_o, mult_issue_o, ldst_issue_o, int_issue_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic i, input logic l, input logic m, input logic d, input logic f);
    int_ready_i  = i;
    ldst_ready_i = l;
    mult_ready_i = m;
    div_ready_i  = d;
    flush_i      = f;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_cdb(input string tag, input logic v, input logic [1:0] o);
    check({tag, "_valid"}, cdb_valid_o, v);
    if (v) check({tag, "_owner"}, cdb_owner_o, o);
  endtask

  initial begin
    // Reset state with all requests asserted.
    rst_n = 1'b0;
    set_in(1, 1, 1, 1, 0);
    check("rst_issue", iss, 4'b0000);
    check("rst_busy", div_busy_o, 1'b0);
    check("rst_cdb_valid", cdb_valid_o, 1'b0);
    check("rst_cdb_owner", cdb_owner_o, 2'd0);

    // 1: single int request.
    do_reset();
    set_in(1, 0, 0, 0, 0);
    check("t1_issue_t0", iss, 4'b0001);
    check("t1_cdb_t0", cdb_valid_o, 1'b0);
    tick();
    set_in(0, 0, 0, 0, 0);
    check("t1_issue_t1", iss, 4'b0000);
    check_cdb("t1_cdb_t1", 1'b1, OWN_INT);
    tick();
    check("t1_cdb_t2", cdb_valid_o, 1'b0);

    // 2: int/ldst tie alternates.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_in(1, 1, 0, 0, 0);
      else       set_in(0, 0, 0, 0, 0);
      if (k < 4) check($sformatf("t2_issue_%0d", k), iss, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      if (k > 0) check_cdb($sformatf("t2_cdb_%0d", k), 1'b1, (k % 2 == 1) ? OWN_INT : OWN_LDST);
      tick();
    end

    // 3: mult reservation blocks int at t3.
    do_reset();
    set_in(1, 0, 1, 0, 0);
    check("t3_issue_t0", iss, 4'b0100);
    tick();
    set_in(1, 0, 0, 0, 0);
    check("t3_issue_t1", iss, 4'b0001);
    tick();
    set_in(1, 0, 0, 0, 0);
    check("t3_issue_t2", iss, 4'b0001);
    check_cdb("t3_cdb_t2", 1'b1, OWN_INT);
    tick();
    set_in(1, 0, 0, 0, 0);
    check("t3_issue_t3", iss, 4'b0000);
    check_cdb("t3_cdb_t3", 1'b1, OWN_INT);
    tick();
    set_in(1, 0, 0, 0, 0);
    check("t3_issue_t4", iss, 4'b0001);
    check_cdb("t3_cdb_t4", 1'b1, OWN_MULT);
    tick();
    set_in(0, 0, 0, 0, 0);
    check_cdb("t3_cdb_t5", 1'b1, OWN_INT);

    // 4: divider paced every DIV_LAT cycles.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      set_in(0, 0, 0, 1, 0);
      check($sformatf("t4_issue_%0d", k), iss, (k == 0 || k == 7) ? 4'b1000 : 4'b0000);
      check($sformatf("t4_busy_%0d", k), div_busy_o, (k >= 1 && k <= 6) || k == 8);
      if (k == 7) check_cdb("t4_cdb_t7", 1'b1, OWN_DIV);
      if (k == 6) check("t4_cdb_t6", cdb_valid_o, 1'b0);
      tick();
    end
    set_in(0, 0, 0, 0, 0);

    // 5: flush cancels mult reservation, cdb slot 0 still visible in flush cycle.
    do_reset();
    set_in(0, 0, 1, 0, 0);
    check("t5_issue_t0", iss, 4'b0100);
    tick();
    set_in(1, 0, 0, 0, 0);
    check("t5_issue_t1", iss, 4'b0001);
    tick();
    set_in(1, 0, 0, 0, 1);
    check("t5_issue_t2", iss, 4'b0000);
    check_cdb("t5_cdb_t2", 1'b1, OWN_INT);
    tick();
    set_in(1, 0, 0, 0, 0);
    check("t5_cdb_t3", cdb_valid_o, 1'b0);
    check("t5_issue_t3", iss, 4'b0001);
    tick();
    set_in(0, 0, 0, 0, 0);
    check_cdb("t5_cdb_t4", 1'b1, OWN_INT);
    tick();
    check("t5_cdb_t5", cdb_valid_o, 1'b0);

    // 6: async reset with a divide in flight.
    do_reset();
    set_in(0, 0, 0, 1, 0);
    check("t6_issue_t0", iss, 4'b1000);
    tick();
    set_in(1, 0, 0, 0, 0);
    check("t6_issue_t1", iss, 4'b0001);
    check("t6_busy_t1", div_busy_o, 1'b1);
    tick();
    set_in(1, 1, 0, 0, 0);
    check("t6_issue_t2", iss, 4'b0010);
    check_cdb("t6_cdb_t2", 1'b1, OWN_INT);
    rst_n = 1'b0;
    #1;
    check("t6_rst_issue", iss, 4'b0000);
    check("t6_rst_busy", div_busy_o, 1'b0);
    check("t6_rst_valid", cdb_valid_o, 1'b0);
    check("t6_rst_owner", cdb_owner_o, 2'd0);
    rst_n = 1'b1;
    #1;
    check("t6_rel_issue", iss, 4'b0001);
    tick();
    set_in(0, 0, 0, 0, 0);
    check_cdb("t6_cdb_t3", 1'b1, OWN_INT);
    repeat (4) tick();
    check("t6_cdb_t7", cdb_valid_o, 1'b0);
    check("t6_busy_t7", div_busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
